// File: rtl/ibex_pkg.sv
// Shared types for the Ibex alert collector: alert classes and handshake states.
package ibex_pkg;

    localparam int unsigned NumAlertClasses = 3;

    typedef enum logic [1:0] {
        ALERT_MINOR     = 2'd0,
        ALERT_MAJOR_INT = 2'd1,
        ALERT_MAJOR_BUS = 2'd2
    } alert_class_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKD = 2'd2
    } alert_hs_state_e;

endpackage

// File: rtl/ibex_alert_collector_if.sv
// Alert-handler side of the collector: per-class four-phase req/ack plus liveness ping.
interface ibex_alert_collector_if;

    logic [ibex_pkg::NumAlertClasses-1:0] alert_req;
    logic [ibex_pkg::NumAlertClasses-1:0] alert_ack;
    logic                                 ping_req;
    logic                                 ping_ack;

    // Alert handler drives ack/ping and observes req/ping_ack.
    modport master (input alert_req, ping_ack, output alert_ack, ping_req);
    modport slave  (output alert_req, ping_ack, input alert_ack, ping_req);

endinterface

// File: rtl/ibex_alert_collector_hs.sv
// Single-class four-phase alert handshake: sticky pending bit plus IDLE/REQ/ACKD FSM.
module ibex_alert_hs
    import ibex_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic alert_i,
    input  logic ack_i,
    output logic req_o,
    output logic idle_o
);

    alert_hs_state_e state_q, state_d;
    logic            pending_q, pending_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d   = state_q;
        pending_d = pending_q | alert_i;
        case (state_q)
            IDLE: if (pending_d) state_d = REQ;
            REQ: begin
                if (ack_i) begin
                    state_d   = ACKD;
                    pending_d = alert_i;   // a fresh alert this cycle survives the clear
                end
            end
            ACKD:    if (!ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign req_o  = (state_q == REQ);
    assign idle_o = (state_q == IDLE);

endmodule

// File: rtl/ibex_alert_collector.sv
// Ibex alert collector: per-class handshakes, minor counter, sticky fatal escalation.
// Optional liveness ping response is built only when IBEX_ALERT_PING_EN is defined.
module ibex_alert_collector
    import ibex_pkg::*;
#(
    parameter int unsigned MinorCntWidth  = 8,
    parameter int unsigned MinorThreshold = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alert_minor_i,
    input  logic                       alert_major_internal_i,
    input  logic                       alert_major_bus_i,
    output logic [NumAlertClasses-1:0] alert_req_o,
    input  logic [NumAlertClasses-1:0] alert_ack_i,
    input  logic                       ping_req_i,
    output logic                       ping_ack_o,
    output logic [MinorCntWidth-1:0]   minor_cnt_o,
    output logic                       fatal_o
);

    localparam logic [MinorCntWidth-1:0] CntMax = '1;

    logic [NumAlertClasses-1:0] alert_in;
    logic [NumAlertClasses-1:0] hs_idle;

    assign alert_in[ALERT_MINOR]     = alert_minor_i;
    assign alert_in[ALERT_MAJOR_INT] = alert_major_internal_i;
    assign alert_in[ALERT_MAJOR_BUS] = alert_major_bus_i;

    for (genvar c = 0; c < NumAlertClasses; c++) begin : g_hs
        ibex_alert_hs u_hs (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .alert_i(alert_in[c]),
            .ack_i  (alert_ack_i[c]),
            .req_o  (alert_req_o[c]),
            .idle_o (hs_idle[c])
        );
    end

    logic                     minor_prev_q, minor_prev_d;
    logic [MinorCntWidth-1:0] minor_cnt_q, minor_cnt_d;
    logic                     fatal_q, fatal_d;
    logic [31:0]              minor_cnt_ext;
    logic                     thresh_hit;

    assign minor_cnt_ext = 32'(minor_cnt_q);
    assign thresh_hit    = (MinorThreshold != 0) && (minor_cnt_ext >= MinorThreshold);

    always_comb begin
        minor_prev_d = alert_minor_i;
        minor_cnt_d  = minor_cnt_q;
        if (alert_minor_i && !minor_prev_q && (minor_cnt_q != CntMax)) begin
            minor_cnt_d = minor_cnt_q + MinorCntWidth'(1);
        end
        fatal_d = fatal_q | alert_major_internal_i | alert_major_bus_i | thresh_hit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            minor_prev_q <= 1'b0;
            minor_cnt_q  <= '0;
            fatal_q      <= 1'b0;
        end else begin
            minor_prev_q <= minor_prev_d;
            minor_cnt_q  <= minor_cnt_d;
            fatal_q      <= fatal_d;
        end
    end

    assign minor_cnt_o = minor_cnt_q;
    assign fatal_o     = fatal_q;

`ifdef IBEX_ALERT_PING_EN
    logic ping_prev_q, ping_prev_d;
    logic ping_pend_q, ping_pend_d;
    logic ping_ack_q, ping_ack_d;
    logic ping_want;
    logic all_idle;

    assign all_idle = &hs_idle;

    // One ping is outstanding at most; it is answered only once every class is idle.
    always_comb begin
        ping_prev_d = ping_req_i;
        ping_want   = ping_pend_q | (ping_req_i & ~ping_prev_q);
        ping_ack_d  = ping_want & all_idle;
        ping_pend_d = ping_want & ~all_idle;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ping_prev_q <= 1'b0;
            ping_pend_q <= 1'b0;
            ping_ack_q  <= 1'b0;
        end else begin
            ping_prev_q <= ping_prev_d;
            ping_pend_q <= ping_pend_d;
            ping_ack_q  <= ping_ack_d;
        end
    end

    assign ping_ack_o = ping_ack_q;
`else
    logic unused_ping;
    assign unused_ping = ^{ping_req_i, hs_idle};
    assign ping_ack_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_alert_collector.sv
// Randomized and directed bench for ibex_alert_collector against a transaction-level model.
module tb_ibex_alert_collector;
    import ibex_pkg::*;

    localparam int CntW   = 8;
    localparam int Thr    = 4;
    localparam int CntMax = 255;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            alert_minor_i = 1'b0;
    logic            alert_major_internal_i = 1'b0;
    logic            alert_major_bus_i = 1'b0;
    logic [CntW-1:0] minor_cnt_o;
    logic            fatal_o;

    ibex_alert_collector_if bus_if ();

    always #5 clk_i = ~clk_i;

    ibex_alert_collector #(
        .MinorCntWidth (CntW),
        .MinorThreshold(Thr)
    ) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .alert_minor_i         (alert_minor_i),
        .alert_major_internal_i(alert_major_internal_i),
        .alert_major_bus_i     (alert_major_bus_i),
        .alert_req_o           (bus_if.alert_req),
        .alert_ack_i           (bus_if.alert_ack),
        .ping_req_i            (bus_if.ping_req),
        .ping_ack_o            (bus_if.ping_ack),
        .minor_cnt_o           (minor_cnt_o),
        .fatal_o               (fatal_o)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per class, "raised" = request visible, "await_drop" = acked, waiting for ack low.
    bit [2:0] m_req, m_await_drop, m_pend;
    int       m_cnt;
    bit       m_fatal, m_minor_prev;
    bit       m_ping_prev, m_ping_out, m_ping_ack;

    task automatic model_edge(input bit [2:0] al, input bit [2:0] ack, input bit ping, input bit rst);
        bit [2:0] n_req, n_drop, n_pend;
        bit       quiet, want;
        if (rst) begin
            m_req = '0; m_await_drop = '0; m_pend = '0;
            m_cnt = 0; m_fatal = 0; m_minor_prev = 0;
            m_ping_prev = 0; m_ping_out = 0; m_ping_ack = 0;
            return;
        end
        quiet   = ((m_req | m_await_drop) == 3'b000);
        m_fatal = m_fatal || al[1] || al[2] || (Thr != 0 && m_cnt >= Thr);
        if (al[0] && !m_minor_prev && m_cnt < CntMax) m_cnt++;
        m_minor_prev = al[0];
        for (int c = 0; c < 3; c++) begin
            n_pend[c] = m_pend[c] | al[c];
            n_req[c]  = m_req[c];
            n_drop[c] = m_await_drop[c];
            if (m_await_drop[c]) begin
                n_drop[c] = ack[c];
            end else if (m_req[c]) begin
                if (ack[c]) begin
                    n_req[c]  = 0;
                    n_drop[c] = 1;
                    n_pend[c] = al[c];
                end
            end else begin
                n_req[c] = m_pend[c] | al[c];
            end
        end
        m_req = n_req; m_await_drop = n_drop; m_pend = n_pend;
`ifdef IBEX_ALERT_PING_EN
        want        = m_ping_out || (ping && !m_ping_prev);
        m_ping_ack  = want && quiet;
        m_ping_out  = want && !quiet;
        m_ping_prev = ping;
`else
        want       = quiet && ping;
        m_ping_ack = 0;
`endif
    endtask

    // Drive one cycle of inputs (called at a negedge), then compare at the following negedge.
    task automatic step(input bit [2:0] al, input bit [2:0] ack, input bit ping, input bit rst);
        alert_minor_i          = al[0];
        alert_major_internal_i = al[1];
        alert_major_bus_i      = al[2];
        bus_if.alert_ack       = ack;
        bus_if.ping_req        = ping;
        rst_i                  = rst;
        model_edge(al, ack, ping, rst);
        @(negedge clk_i);
        check("req", 32'(bus_if.alert_req), 32'(m_req));
        check("ping_ack", 32'(bus_if.ping_ack), 32'(m_ping_ack));
        check("minor_cnt", 32'(minor_cnt_o), m_cnt);
        check("fatal", 32'(fatal_o), 32'(m_fatal));
    endtask

    task automatic do_reset();
        step(3'b000, 3'b000, 1'b0, 1'b1);
    endtask

    initial begin
        bus_if.alert_ack = '0;
        bus_if.ping_req  = 1'b0;
        @(negedge clk_i);
        do_reset();
        check("rst_req", 32'(bus_if.alert_req), 0);
        check("rst_cnt", 32'(minor_cnt_o), 0);
        check("rst_fatal", 32'(fatal_o), 0);
        check("rst_ping", 32'(bus_if.ping_ack), 0);

        // Single minor alert through a full four-phase handshake.
        step(3'b001, 3'b000, 0, 0);
        check("hs_req_rise", 32'(bus_if.alert_req), 1);
        step(3'b000, 3'b000, 0, 0);
        step(3'b000, 3'b000, 0, 0);
        step(3'b000, 3'b001, 0, 0);
        check("hs_req_fall", 32'(bus_if.alert_req), 0);
        step(3'b000, 3'b001, 0, 0);
        check("hs_ackd_hold", 32'(bus_if.alert_req), 0);
        step(3'b000, 3'b000, 0, 0);
        check("hs_cnt", 32'(minor_cnt_o), 1);
        check("hs_fatal", 32'(fatal_o), 0);
        step(3'b000, 3'b000, 0, 0);
        check("hs_idle_req", 32'(bus_if.alert_req), 0);

        // Ack while idle must not raise or disturb anything.
        step(3'b000, 3'b111, 0, 0);
        check("idle_ack_ignored", 32'(bus_if.alert_req), 0);
        step(3'b000, 3'b000, 0, 0);

        // Threshold escalation and counter saturation.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(3'b001, 3'b000, 0, 0);
            step(3'b000, 3'b000, 0, 0);
        end
        step(3'b001, 3'b000, 0, 0);
        check("thr_cnt4", 32'(minor_cnt_o), 4);
        check("thr_fatal_early", 32'(fatal_o), 0);
        step(3'b000, 3'b000, 0, 0);
        check("thr_fatal", 32'(fatal_o), 1);
        for (int i = 0; i < 300; i++) begin
            step(3'b001, 3'b000, 0, 0);
            step(3'b000, 3'b000, 0, 0);
        end
        check("sat_cnt", 32'(minor_cnt_o), 255);

        // Major bus + minor together; reset aborts handshakes in flight.
        do_reset();
        step(3'b101, 3'b000, 0, 0);
        check("both_req", 32'(bus_if.alert_req), 5);
        check("both_fatal", 32'(fatal_o), 1);

        do_reset();
        step(3'b010, 3'b000, 0, 0);
        check("mid_req", 32'(bus_if.alert_req), 2);
        step(3'b001, 3'b000, 0, 0);
        step(3'b000, 3'b000, 0, 1);
        check("mid_rst_req", 32'(bus_if.alert_req), 0);
        check("mid_rst_cnt", 32'(minor_cnt_o), 0);
        check("mid_rst_fatal", 32'(fatal_o), 0);

        // Alert held high through the handshake is re-requested.
        do_reset();
        step(3'b001, 3'b000, 0, 0);
        step(3'b001, 3'b001, 0, 0);
        check("held_ackd", 32'(bus_if.alert_req), 0);
        step(3'b001, 3'b000, 0, 0);
        check("held_idle", 32'(bus_if.alert_req), 0);
        step(3'b001, 3'b000, 0, 0);
        check("held_rereq", 32'(bus_if.alert_req), 1);

        // Ping deferred behind an active class-0 handshake.
        do_reset();
        step(3'b001, 3'b000, 0, 0);
        step(3'b000, 3'b000, 1, 0);
        check("ping_defer0", 32'(bus_if.ping_ack), 0);
        step(3'b000, 3'b000, 1, 0);
        step(3'b000, 3'b001, 1, 0);
        step(3'b000, 3'b000, 1, 0);
        check("ping_defer1", 32'(bus_if.ping_ack), 0);
        step(3'b000, 3'b000, 1, 0);
`ifdef IBEX_ALERT_PING_EN
        check("ping_pulse", 32'(bus_if.ping_ack), 1);
`else
        check("ping_off", 32'(bus_if.ping_ack), 0);
`endif
        step(3'b000, 3'b000, 1, 0);
        check("ping_pulse_end", 32'(bus_if.ping_ack), 0);

        // Randomized traffic with sparse alerts, random acks/pings and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            bit [2:0] al, ack;
            bit       ping, rst;
            for (int c = 0; c < 3; c++) al[c] = ($urandom_range(0, 5) == 0);
            ack  = 3'($urandom);
            ping = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            step(al, ack, ping, rst);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/ibex_alert_collector.md
IBEX_ALERT_COLLECTOR -- requirements
Module: ibex_alert_collector

Interface
REQ-001 SHALL have parameter MinorCntWidth, default 8, width of saturating minor-alert counter.
REQ-002 SHALL have parameter MinorThreshold, default 4, minor count that escalates to fatal; 0 disables escalation.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alert_minor_i  input  1  minor alert level from lockstep checker.
REQ-006 SHALL have port alert_major_internal_i  input  1  major internal alert level.
REQ-007 SHALL have port alert_major_bus_i  input  1  major bus alert level.
REQ-008 SHALL have port alert_req_o  output  3  per-class four-phase request to system alert handler, index per alert_class_e.
REQ-009 SHALL have port alert_ack_i  input  3  per-class four-phase acknowledge.
REQ-010 SHALL have port ping_req_i  input  1  liveness ping from alert handler.
REQ-011 SHALL have port ping_ack_o  output  1  one-cycle ping response pulse.
REQ-012 SHALL have port minor_cnt_o  output  MinorCntWidth  count of minor alert events.
REQ-013 SHALL have port fatal_o  output  1  sticky escalated fatal indication.

Function
REQ-014 Per class: pending bit set in any cycle its alert input is 1; set wins over clear in the same cycle.
REQ-015 Per-class FSM IDLE->REQ when pending=1; alert_req_o[c]=1 only in REQ.
REQ-016 REQ->ACKD when alert_ack_i[c]=1; pending cleared on this transition unless input high that cycle (REQ-014).
REQ-017 ACKD->IDLE when alert_ack_i[c]=0; ack held high keeps FSM in ACKD, req stays 0.
REQ-018 alert_req_o[c] SHALL rise one cycle after the first cycle input c is high (latency 1 from IDLE).
REQ-019 ack asserted in IDLE or ACKD-before-drop SHALL be ignored (no state change, no pending clear).
REQ-020 Classes SHALL be independent; simultaneous alerts on all three raise all three requests in the same cycle.
REQ-021 minor_cnt_o SHALL increment by 1 on each 0->1 edge of alert_minor_i; saturate at 2^MinorCntWidth-1, no wrap.
REQ-022 fatal_o SHALL set the cycle after any major input is 1, or after minor_cnt_o reaches MinorThreshold (if nonzero); cleared only by reset.

Reset
REQ-023 On rst_i=1 at clock edge: all FSMs IDLE, pending=0, alert_req_o=0, ping_ack_o=0, minor_cnt_o=0, fatal_o=0, edge-detect registers=0.
REQ-024 Reset mid-handshake SHALL abort it; alert inputs high in the first post-reset cycle SHALL be captured normally.

Configuration
REQ-025 With IBEX_ALERT_PING_EN defined: on a 0->1 edge of ping_req_i, ping_ack_o pulses 1 cycle later, deferred until all class FSMs IDLE; further edges while one ping is outstanding are dropped.
REQ-026 Without IBEX_ALERT_PING_EN: ping_req_i ignored, ping_ack_o constant 0, no ping logic synthesised.

Structure
REQ-027 ibex_pkg SHALL hold alert_class_e (ALERT_MINOR=0, ALERT_MAJOR_INT=1, ALERT_MAJOR_BUS=2), NumAlertClasses=3, and alert_hs_state_e (IDLE, REQ, ACKD).
REQ-028 Per-class handshake (pending bit + FSM) SHALL be sub-module ibex_alert_hs, instantiated NumAlertClasses times.

Verification
REQ-029 alert_minor_i high 1 cycle at t0 -> alert_req_o=3'b001 at t0+1; ack high t0+3 -> req 0 at t0+4; ack low t0+5 -> IDLE, minor_cnt_o=1, fatal_o=0.
REQ-030 4 separate minor pulses, MinorThreshold=4 -> minor_cnt_o=4, fatal_o=1 the cycle after 4th count; 300 pulses with width 8 -> minor_cnt_o=255.
REQ-031 alert_major_bus_i and alert_minor_i high same cycle -> alert_req_o=3'b101 next cycle, fatal_o=1 next cycle.
REQ-032 Alert input held high through ack -> after ACKD->IDLE, request re-raised next cycle.
REQ-033 rst_i asserted while alert_req_o=3'b010 in REQ -> next cycle all outputs 0, minor_cnt_o=0, fatal_o=0.
REQ-034 IBEX_ALERT_PING_EN defined, ping_req_i rises with class 0 in REQ -> ping_ack_o stays 0 until class 0 returns IDLE, then 1-cycle pulse; undefined -> ping_ack_o always 0.
